// File: rtl/dice_display_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// dice_display_scan_ctrl_if
//   Bus between the dice roller core and the two-digit display scan controller.
//
//   Core -> controller (master drives, slave receives):
//      ena        design enable; low forces display dark and scan idle
//      digit1     ones digit value (0-9 shown, 10-15 blank)
//      digit10    tens digit value (0-9 shown, 10-15 blank)
//      blank_lz   1 = blank tens digit when it is zero
//      seg_pol    segment level that lights a segment
//      com_pol    common level that activates a digit
//   Controller -> pins/core:
//      seg        segment bus {dp,g,f,e,d,c,b,a}
//      com1       ones-digit common
//      com10      tens-digit common
//      com_oe     output enables for {com10,com1}
//      frame_tick one-cycle pulse on each entry to the ones-digit slot
// -----------------------------------------------------------------------------
interface dice_display_scan_ctrl_if;
   logic       ena;
   logic [3:0] digit1;
   logic [3:0] digit10;
   logic       blank_lz;
   logic       seg_pol;
   logic       com_pol;
   logic [7:0] seg;
   logic       com1;
   logic       com10;
   logic [1:0] com_oe;
   logic       frame_tick;

   modport master (
      output ena, digit1, digit10, blank_lz, seg_pol, com_pol,
      input  seg, com1, com10, com_oe, frame_tick
   );

   modport slave (
      input  ena, digit1, digit10, blank_lz, seg_pol, com_pol,
      output seg, com1, com10, com_oe, frame_tick
   );
endinterface

// File: rtl/dice_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// dice_display_scan_ctrl
//   Time-multiplexes the two 7-segment digits of the dice roller over one
//   shared segment bus. A fixed four-phase scan (ON1, DEAD_A, ON10, DEAD_B)
//   lights the ones digit, blanks both commons, lights the tens digit, blanks
//   again. Dead phases stop ghosting between digits. Polarity of segments and
//   commons is selected at runtime and applied combinationally on the outputs.
//
//   Ports:
//      clk    system clock
//      rst_n  asynchronous active-low reset
//      bus    slave side of dice_display_scan_ctrl_if (digits, enables,
//             polarity selects in; segments, commons, enables, tick out)
//
//   Parameters:
//      SCAN_DIV     cycles each digit is lit per slot (>= 2)
//      DEAD_CYCLES  cycles with both commons inactive between slots (>= 1)
// -----------------------------------------------------------------------------
module dice_display_scan_ctrl #(
   parameter int unsigned SCAN_DIV    = 1024,
   parameter int unsigned DEAD_CYCLES = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   dice_display_scan_ctrl_if.slave   bus
);

   localparam int unsigned MAX_LEN = (SCAN_DIV > DEAD_CYCLES) ? SCAN_DIV : DEAD_CYCLES;
   localparam int unsigned CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   localparam logic [CW-1:0] ON_LAST   = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);

   localparam logic [1:0] ST_ON1    = 2'd0;
   localparam logic [1:0] ST_DEAD_A = 2'd1;
   localparam logic [1:0] ST_ON10   = 2'd2;
   localparam logic [1:0] ST_DEAD_B = 2'd3;

   // Segment patterns, bit order {dp,g,f,e,d,c,b,a}; dp is never lit.
   function automatic logic [7:0] decode(input logic [3:0] d);
      logic [7:0] p;
      case (d)
         4'd0:    p = 8'b0011_1111;
         4'd1:    p = 8'b0000_0110;
         4'd2:    p = 8'b0101_1011;
         4'd3:    p = 8'b0100_1111;
         4'd4:    p = 8'b0110_0110;
         4'd5:    p = 8'b0110_1101;
         4'd6:    p = 8'b0111_1101;
         4'd7:    p = 8'b0000_0111;
         4'd8:    p = 8'b0111_1111;
         4'd9:    p = 8'b0110_1111;
         default: p = 8'b0000_0000;
      endcase
      return p;
   endfunction

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic [7:0]    lit_q,   lit_d;
   logic          act1_q,  act1_d;
   logic          act10_q, act10_d;
   logic [1:0]    oe_q,    oe_d;
   logic          tick_q,  tick_d;
   logic          phase_last;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + CW'(1);
      lit_d      = lit_q;
      act1_d     = act1_q;
      act10_d    = act10_q;
      tick_d     = 1'b0;
      // Enables come up on the first clock out of reset and stay up.
      oe_d       = 2'b11;
      phase_last = ((state_q == ST_ON1) || (state_q == ST_ON10)) ?
                   (cnt_q == ON_LAST) : (cnt_q == DEAD_LAST);

      // Disable takes priority over a phase end on the same edge.
      if (!bus.ena) begin
         state_d = ST_DEAD_B;
         cnt_d   = '0;
         lit_d   = '0;
         act1_d  = 1'b0;
         act10_d = 1'b0;
      end else if (phase_last) begin
         cnt_d = '0;
         case (state_q)
            ST_ON1: begin
               state_d = ST_DEAD_A;
               lit_d   = '0;
               act1_d  = 1'b0;
               act10_d = 1'b0;
            end
            ST_DEAD_A: begin
               state_d = ST_ON10;
               if (bus.blank_lz && (bus.digit10 == 4'd0)) begin
                  lit_d   = '0;
                  act10_d = 1'b0;
               end else begin
                  lit_d   = decode(bus.digit10);
                  act10_d = 1'b1;
               end
            end
            ST_ON10: begin
               state_d = ST_DEAD_B;
               lit_d   = '0;
               act1_d  = 1'b0;
               act10_d = 1'b0;
            end
            default: begin
               state_d = ST_ON1;
               lit_d   = decode(bus.digit1);
               act1_d  = 1'b1;
               tick_d  = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_DEAD_B;
         cnt_q   <= '0;
         lit_q   <= '0;
         act1_q  <= 1'b0;
         act10_q <= 1'b0;
         oe_q    <= 2'b00;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lit_q   <= lit_d;
         act1_q  <= act1_d;
         act10_q <= act10_d;
         oe_q    <= oe_d;
         tick_q  <= tick_d;
      end
   end

   // Polarity is applied after the registers so a change shows immediately.
   assign bus.seg        = bus.seg_pol ? lit_q : ~lit_q;
   assign bus.com1       = act1_q  ? bus.com_pol : ~bus.com_pol;
   assign bus.com10      = act10_q ? bus.com_pol : ~bus.com_pol;
   assign bus.com_oe     = oe_q;
   assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_dice_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dice_display_scan_ctrl
//   Directed bench for dice_display_scan_ctrl with SCAN_DIV=8, DEAD_CYCLES=2.
//   Inputs are driven and outputs sampled on the falling clock edge.
//   Within a frame, counting falling edges from the one where frame_tick is
//   seen (t0): ones slot t0..t0+7, dead t0+8..t0+9, tens slot t0+10..t0+17,
//   dead t0+18..t0+19, next tick at t0+20.
// -----------------------------------------------------------------------------
module tb_dice_display_scan_ctrl;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   dice_display_scan_ctrl_if dut_if ();

   dice_display_scan_ctrl #(
      .SCAN_DIV    (8),
      .DEAD_CYCLES (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dut_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to the falling edge on which a fresh frame_tick is seen.
   task wait_frame;
      int n;
      begin
         n = 0;
         @(negedge clk);
         while (!dut_if.frame_tick && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (!dut_if.frame_tick) begin
            checks++;
            errors++;
            $display("FAIL wait_frame: frame_tick=%b required 1 within 100 cycles", dut_if.frame_tick);
         end
      end
   endtask

   task test_reset;
      begin
         rst_n           = 1'b0;
         dut_if.ena      = 1'b1;
         dut_if.digit1   = 4'd7;
         dut_if.digit10  = 4'd4;
         dut_if.blank_lz = 1'b0;
         dut_if.seg_pol  = 1'b1;
         dut_if.com_pol  = 1'b0;
         repeat (3) @(negedge clk);
         checks++;
         if (dut_if.com_oe !== 2'b00) begin
            errors++; $display("FAIL reset_com_oe: got %b required 00", dut_if.com_oe);
         end
         checks++;
         if (dut_if.seg !== 8'h00) begin
            errors++; $display("FAIL reset_seg: got %b required 00000000", dut_if.seg);
         end
         checks++;
         if (dut_if.com1 !== 1'b1 || dut_if.com10 !== 1'b1) begin
            errors++; $display("FAIL reset_com: got com1=%b com10=%b required 1 1", dut_if.com1, dut_if.com10);
         end
         checks++;
         if (dut_if.frame_tick !== 1'b0) begin
            errors++; $display("FAIL reset_tick: got %b required 0", dut_if.frame_tick);
         end
         rst_n = 1'b1;
         @(negedge clk);
         checks++;
         if (dut_if.com_oe !== 2'b11 || dut_if.com1 !== 1'b1) begin
            errors++; $display("FAIL first_edge: got com_oe=%b com1=%b required 11 1", dut_if.com_oe, dut_if.com1);
         end
         @(negedge clk);
         checks++;
         if (dut_if.com1 !== 1'b0 || dut_if.seg !== 8'b0000_0111 || dut_if.frame_tick !== 1'b1) begin
            errors++; $display("FAIL first_on1: got com1=%b seg=%b tick=%b required 0 00000111 1",
                               dut_if.com1, dut_if.seg, dut_if.frame_tick);
         end
         @(negedge clk);
         checks++;
         if (dut_if.frame_tick !== 1'b0) begin
            errors++; $display("FAIL tick_width: got %b required 0", dut_if.frame_tick);
         end
      end
   endtask

   task test_steady;
      int n;
      begin
         wait_frame();
         for (int i = 0; i < 20; i++) begin
            logic [7:0] es;
            logic       e1;
            logic       e10;
            if (i < 8) begin
               es = 8'b0000_0111; e1 = 1'b0; e10 = 1'b1;
            end else if (i >= 10 && i < 18) begin
               es = 8'b0110_0110; e1 = 1'b1; e10 = 1'b0;
            end else begin
               es = 8'h00; e1 = 1'b1; e10 = 1'b1;
            end
            checks++;
            if (dut_if.seg !== es || dut_if.com1 !== e1 || dut_if.com10 !== e10) begin
               errors++;
               $display("FAIL steady_cycle%0d: got seg=%b com1=%b com10=%b required %b %b %b",
                        i, dut_if.seg, dut_if.com1, dut_if.com10, es, e1, e10);
            end
            @(negedge clk);
         end
         // Now at t0+20; a tick here confirms the 20-cycle frame period.
         n = 20;
         checks++;
         if (dut_if.frame_tick !== 1'b1) begin
            errors++; $display("FAIL frame_period: tick=%b at cycle %0d required 1", dut_if.frame_tick, n);
         end
      end
   endtask

   task test_blanking;
      begin
         dut_if.digit1   = 4'd3;
         dut_if.digit10  = 4'd0;
         dut_if.blank_lz = 1'b1;
         wait_frame();
         checks++;
         if (dut_if.seg !== 8'b0100_1111) begin
            errors++; $display("FAIL ones_3: got %b required 01001111", dut_if.seg);
         end
         repeat (10) @(negedge clk);
         checks++;
         if (dut_if.com10 !== 1'b1 || dut_if.seg !== 8'h00) begin
            errors++; $display("FAIL lz_blank: got com10=%b seg=%b required 1 00000000", dut_if.com10, dut_if.seg);
         end
         dut_if.blank_lz = 1'b0;
         wait_frame();
         repeat (10) @(negedge clk);
         checks++;
         if (dut_if.com10 !== 1'b0 || dut_if.seg !== 8'b0011_1111) begin
            errors++; $display("FAIL lz_shown: got com10=%b seg=%b required 0 00111111", dut_if.com10, dut_if.seg);
         end
         dut_if.digit1 = 4'd12;
         wait_frame();
         checks++;
         if (dut_if.seg !== 8'h00) begin
            errors++; $display("FAIL ones_blank12: got %b required 00000000", dut_if.seg);
         end
      end
   endtask

   task test_sampling;
      begin
         dut_if.digit1 = 4'd2;
         wait_frame();
         repeat (2) @(negedge clk);
         dut_if.digit1 = 4'd5;
         for (int i = 2; i < 8; i++) begin
            checks++;
            if (dut_if.seg !== 8'b0101_1011) begin
               errors++; $display("FAIL mid_slot_hold%0d: got %b required 01011011", i, dut_if.seg);
            end
            @(negedge clk);
         end
         wait_frame();
         checks++;
         if (dut_if.seg !== 8'b0110_1101) begin
            errors++; $display("FAIL next_slot_5: got %b required 01101101", dut_if.seg);
         end
      end
   endtask

   task test_polarity;
      begin
         dut_if.digit1 = 4'd1;
         wait_frame();
         checks++;
         if (dut_if.seg !== 8'b0000_0110) begin
            errors++; $display("FAIL pol_before: got %b required 00000110", dut_if.seg);
         end
         repeat (2) @(negedge clk);
         dut_if.seg_pol = 1'b0;
         #1;
         checks++;
         if (dut_if.seg !== 8'b1111_1001) begin
            errors++; $display("FAIL seg_pol_flip: got %b required 11111001", dut_if.seg);
         end
         dut_if.com_pol = 1'b1;
         #1;
         checks++;
         if (dut_if.com1 !== 1'b1 || dut_if.com10 !== 1'b0) begin
            errors++; $display("FAIL com_pol_flip: got com1=%b com10=%b required 1 0", dut_if.com1, dut_if.com10);
         end
         dut_if.seg_pol = 1'b1;
         dut_if.com_pol = 1'b0;
      end
   endtask

   task test_ena_and_async_reset;
      begin
         dut_if.digit1  = 4'd7;
         dut_if.digit10 = 4'd4;
         wait_frame();
         repeat (11) @(negedge clk);
         checks++;
         if (dut_if.com10 !== 1'b0 || dut_if.seg !== 8'b0110_0110) begin
            errors++; $display("FAIL ena_pre_on10: got com10=%b seg=%b required 0 01100110", dut_if.com10, dut_if.seg);
         end
         dut_if.ena = 1'b0;
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (dut_if.com1 !== 1'b1 || dut_if.com10 !== 1'b1 || dut_if.seg !== 8'h00 || dut_if.frame_tick !== 1'b0) begin
               errors++;
               $display("FAIL ena_low%0d: got com1=%b com10=%b seg=%b tick=%b required 1 1 00000000 0",
                        i, dut_if.com1, dut_if.com10, dut_if.seg, dut_if.frame_tick);
            end
         end
         dut_if.ena = 1'b1;
         @(negedge clk);
         checks++;
         if (dut_if.com1 !== 1'b1 || dut_if.frame_tick !== 1'b0) begin
            errors++; $display("FAIL ena_resume_dead: got com1=%b tick=%b required 1 0", dut_if.com1, dut_if.frame_tick);
         end
         @(negedge clk);
         checks++;
         if (dut_if.com1 !== 1'b0 || dut_if.frame_tick !== 1'b1 || dut_if.seg !== 8'b0000_0111) begin
            errors++; $display("FAIL ena_resume_on1: got com1=%b tick=%b seg=%b required 0 1 00000111",
                               dut_if.com1, dut_if.frame_tick, dut_if.seg);
         end
         repeat (3) @(negedge clk);
         rst_n = 1'b0;
         #1;
         checks++;
         if (dut_if.seg !== 8'h00 || dut_if.com1 !== 1'b1 || dut_if.com10 !== 1'b1 || dut_if.com_oe !== 2'b00) begin
            errors++; $display("FAIL async_reset: got seg=%b com1=%b com10=%b com_oe=%b required 00000000 1 1 00",
                               dut_if.seg, dut_if.com1, dut_if.com10, dut_if.com_oe);
         end
         @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_steady();
      test_blanking();
      test_sampling();
      test_polarity();
      test_ena_and_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dice_display_scan_ctrl.md
Name: dice_display_scan_ctrl

Overview:
Time-multiplexes the two-digit 7-segment display of the dice roller over one shared segment bus (uo_out) and two common lines (uio[0] = ones digit, uio[1] = tens digit). A fixed four-phase FSM arbitrates the bus between the ones and tens digits. It inserts dead time between digits to prevent ghosting and applies runtime segment/common polarity selection. It also does optional leading-zero blanking and emits a frame tick that the roll-animation logic uses for sequencing.

Parameters:
SCAN_DIV, 1024, clock cycles each digit is lit per slot; legal range >= 2
DEAD_CYCLES, 16, clock cycles with both commons inactive between slots; legal range >= 1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; low forces display dark and FSM idle
digit1  input  4  ones digit value, 0-9 displayed, 10-15 blank
digit10  input  4  tens digit value, 0-9 displayed, 10-15 blank
blank_lz  input  1  1 = blank tens digit when digit10 == 0
seg_pol  input  1  segment level that lights a segment (from uio_in[6])
com_pol  input  1  common level that activates a digit (from uio_in[7])
seg  output  8  segment bus {dp,g,f,e,d,c,b,a}; dp never lit
com1  output  1  ones-digit common
com10  output  1  tens-digit common
com_oe  output  2  output enables for {com10,com1}
frame_tick  output  1  one-cycle pulse on each entry to the ones-digit slot

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n). All state registers clear immediately on rst_n low.
- Registered state:
  - 2-bit FSM: ON1, DEAD_A, ON10, DEAD_B.
  - Cycle counter, width $clog2(max(SCAN_DIV, DEAD_CYCLES)).
  - lit[7:0], act1, act10, com_oe_r[1:0], frame_tick.
- Reset values: FSM = DEAD_B; counter = 0; lit = 0; act1 = act10 = 0; com_oe_r = 2'b00; frame_tick = 0.
- First edge with rst_n high: com_oe_r <= 2'b11. It stays 11 until the next reset.
- Outputs are combinational from registers plus polarity inputs, so a polarity change takes effect in the same cycle:
  - seg = seg_pol ? lit : ~lit
  - com1 = act1 ? com_pol : ~com_pol
  - com10 = act10 ? com_pol : ~com_pol
  - com_oe = com_oe_r
- Decode from lit, bit order {dp,g..a}:
  - 0=00111111, 1=00000110, 2=01011011, 3=01001111, 4=01100110
  - 5=01101101, 6=01111101, 7=00000111, 8=01111111, 9=01101111
  - 10..15 = 00000000
- Phase timing:
  - Counter increments each cycle while ena = 1.
  - ON phase length = SCAN_DIV cycles; DEAD phase length = DEAD_CYCLES cycles.
  - When counter == length-1: counter <= 0 and FSM advances ON1 -> DEAD_A -> ON10 -> DEAD_B -> ON1.
  - Frame period = 2*(SCAN_DIV + DEAD_CYCLES) cycles.
- Actions at each transition edge:
  - Entering ON1: lit <= decode(digit1); act1 <= 1; frame_tick <= 1 for that single cycle.
  - Entering ON10: lit <= decode(digit10); act10 <= 1.
    - If blank_lz = 1 and digit10 == 0: lit <= 0 and act10 stays 0.
  - Entering DEAD_A or DEAD_B: lit <= 0; act1 <= 0; act10 <= 0.
  - Never are act1 and act10 both 1.
- Digit sampling: digits are sampled only at the edge entering an ON phase. Changes mid-slot are ignored until that digit's next slot. Latency from sample edge to visible seg = 0 cycles after that edge.
- ena low: at the next edge FSM <= DEAD_B, counter <= 0, lit <= 0, act1 = act10 = 0, frame_tick <= 0. This holds while ena is low.
- ena re-asserted: normal sequence resumes from DEAD_B. The first ON1 entry occurs DEAD_CYCLES cycles later.
- Reset mid-slot: commons go inactive and seg goes dark immediately (asynchronous), and com_oe drops to 00.
- Simultaneous ena low and phase-end on the same edge: ena low wins.

Test Plan:
1. SCAN_DIV=8, DEAD_CYCLES=2, seg_pol=1, com_pol=0, digit1=7, digit10=4; assert then release rst_n:
   - During reset: com_oe=00, seg=00000000, com1=com10=1.
   - 1st edge after release: com_oe=11.
   - 2 edges later: com1=0, seg=00000111, frame_tick=1 for 1 cycle.
2. Same settings, steady state:
   - 8 cycles com1=0/seg=00000111.
   - 2 cycles seg=0 with com1=com10=1.
   - 8 cycles com10=0/seg=01100110.
   - 2 dead cycles; frame_tick period = 20 cycles.
3. digit1=3, digit10=0, blank_lz=1:
   - Tens slot has com10 inactive and seg all-off.
   - With blank_lz=0 the tens slot shows seg=00111111.
   - digit1=12 gives a dark ones slot.
4. digit1 changes 2 -> 5 at cycle 3 of the ON1 slot:
   - seg stays 01011011 to the end of the slot.
   - Next ON1 slot shows 01101101.
5. seg_pol 1 -> 0 mid-slot with digit1=1: seg changes 00000110 -> 11111001 in the same cycle; com_pol flip inverts com1 in the same cycle.
6. ena driven low mid-ON10:
   - Next edge: both commons inactive, seg dark.
   - Re-assert: ON1 begins after 2 cycles.
   - rst_n low mid-ON1 blanks the display without waiting for a clock edge.
